// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with HI/LO registers (radix-2 shift-add multiply, restoring divide).
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_nx, res;
  logic is_mul, dz, neg_q, neg_r, sa, sb;
  logic [WIDTH:0] sum, sh, diff;
  always_comb begin
    sa = ~op[0] & a[WIDTH-1];
    sb = ~op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = sh - {1'b0, m};
    // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
    acc_nx = is_mul ? {sum, acc[WIDTH-1:1]} :
             diff[WIDTH] ? {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                           {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    res = dz ? acc :
          is_mul ? (neg_q ? -acc : acc) :
          {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
           neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st <= IDLE;
      cnt <= '0;
      m <= '0;
      acc <= '0;
      is_mul <= 1'b0;
      dz <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (hi_we) hi <= write_data;
          if (lo_we) lo <= write_data;
          if (start) begin
            is_mul <= ~op[1];
            neg_q <= sa ^ sb;
            neg_r <= sa;
            busy <= 1'b1;
            cnt <= '0;
            dz <= op[1] && b == '0;
            m <= op[1] ? mag_b : mag_a;
            acc <= (op[1] && b == '0) ? {a, {WIDTH{1'b1}}} :
                   {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            st <= (op[1] && b == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) st <= FIX;
        end
        FIX: begin
          hi <= res[2*WIDTH-1:WIDTH];
          lo <= res[WIDTH-1:0];
          busy <= 1'b0;
          done <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed self-checking bench for mdu against a 64-bit arithmetic reference model.
module tb_mdu;
  logic clk = 0, clr = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, write_data = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_hl;
  logic [1:0] cur_op;
  logic [31:0] cur_b;

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (o[1] && y == 0) return {x, 32'hFFFF_FFFF};
    sx = o[0] ? longint'(x) : longint'($signed(x));
    sy = o[0] ? longint'(y) : longint'($signed(y));
    if (!o[1]) return 64'(sx * sy);
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_hl = model(o, x, y);
    cur_op = o;
    cur_b = y;
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
  endtask

  // poke: drive MTHI/MTLO and a second start mid-operation; they must be dropped.
  task automatic finish(input bit poke);
    int n;
    bit early;
    n = 0;
    early = 0;
    while (busy && n < 100) begin
      if (done) early = 1;
      if (poke && n == 5) begin
        start = 1; op = 2'd3; a = 32'hDEAD; b = 32'h3; hi_we = 1; lo_we = 1; write_data = 32'hCAFE_F00D;
      end
      if (poke && n == 6) begin
        start = 0; hi_we = 0; lo_we = 0;
      end
      if (n == 1 && !(cur_op[1] && cur_b == 0)) chk("stale_hilo", {hi, lo}, exp_stale);
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), (cur_op[1] && cur_b == 0) ? 64'd1 : 64'd33);
    chk("done_while_busy", 64'(early), 64'd0);
    chk("done", 64'(done), 64'd1);
    chk("hilo", {hi, lo}, exp_hl);
  endtask

  logic [63:0] exp_stale;

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_stale = {hi, lo};
    launch(o, x, y);
    finish(0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [1:0] o;
    #12;
    chk("rst_state", {60'(0), busy, done, 2'b0}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    run(2'd1, 32'hFFFF_FFFF, 32'd2);
    run(2'd0, 32'hFFFF_FFFF, 32'd2);
    run(2'd0, 32'h8000_0000, 32'h8000_0000);
    run(2'd3, 32'd7, 32'd2);
    run(2'd2, 32'hFFFF_FFF9, 32'd2);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'd2, 32'd5, 32'd0);
    run(2'd3, 32'h1234_5678, 32'd0);
    // MTHI / MTLO in idle
    hi_we = 1; write_data = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    chk("mthi", 64'(hi), 64'h1234);
    lo_we = 1; write_data = 32'h55AA;
    @(negedge clk);
    lo_we = 0;
    chk("mtlo", {hi, lo}, {32'h1234, 32'h55AA});
    // Interference mid-operation must not change the result
    exp_stale = {hi, lo};
    launch(2'd1, 32'h0001_0003, 32'h0002_0005);
    finish(1);
    // Back-to-back: start while done is high; MTHI on the same edge as start
    hi_we = 1; write_data = 32'hABCD;
    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    hi_we = 0;
    chk("mthi_with_start", 64'(hi), 64'hABCD);
    exp_stale = {hi, lo};
    finish(0);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: x = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        3: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run(o, x, y);
    end
    // Reset mid-operation
    launch(2'd0, 32'h0BAD_BEEF, 32'h0000_1111);
    repeat (9) @(negedge clk);
    clr = 1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clr = 0;
    begin
      bit seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) seen = 1;
      end
      chk("clr_no_done", 64'(seen), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
